// File: rtl/pong_score_scanner.sv
// Time-multiplexed 4-digit 7-segment scoreboard driver: clamps and converts two
// binary scores to BCD with a shared double-dabble FSM, then scans them with dead time and blink.
module pong_score_scanner #(
    parameter int CLK_DIV      = 100000,
    parameter int SCORE_W      = 7,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SCORE_W-1:0] score_l,
    input  logic [SCORE_W-1:0] score_r,
    input  logic               score_valid,
    input  logic               blink_l,
    input  logic               blink_r,
    output logic               busy,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SH_W  = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [FR_W-1:0]    FR_LAST   = FR_W'(BLINK_FRAMES - 1);
    localparam logic [SH_W-1:0]    SH_LAST   = SH_W'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(99);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic [SCORE_W-1:0] clamp99(input logic [SCORE_W-1:0] v);
        if (v > SCORE_MAX) begin
            return SCORE_MAX;
        end else begin
            return v;
        end
    endfunction

    // One double-dabble step on a two-digit BCD value: adjust each nibble, shift in b.
    function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic b);
        logic [3:0] t;
        logic [3:0] u;
        t = bcd[7:4];
        u = bcd[3:0];
        if (t >= 4'd5) begin
            t = t + 4'd3;
        end else begin
            t = t;
        end
        if (u >= 4'd5) begin
            u = u + 4'd3;
        end else begin
            u = u;
        end
        return {t[2:0], u, b};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] bin_l_q, bin_l_d, bin_r_q, bin_r_d;
    logic [7:0]         bcd_l_q, bcd_l_d, bcd_r_q, bcd_r_d;
    logic [7:0]         disp_l_q, disp_l_d, disp_r_q, disp_r_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [FR_W-1:0]    frame_q, frame_d;
    logic               phase_q, phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         nib_s;
    logic               tens_s;
    logic               blink_s;

    // Conversion FSM; a new strobe in any state restarts at LOAD and skips a pending commit.
    always_comb begin
        state_d  = state_q;
        bin_l_d  = bin_l_q;
        bin_r_d  = bin_r_q;
        bcd_l_d  = bcd_l_q;
        bcd_r_d  = bcd_r_q;
        disp_l_d = disp_l_q;
        disp_r_d = disp_r_q;
        sh_cnt_d = sh_cnt_q;
        if (score_valid) begin
            state_d = ST_LOAD;
            bin_l_d = clamp99(score_l);
            bin_r_d = clamp99(score_r);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    bcd_l_d  = 8'd0;
                    bcd_r_d  = 8'd0;
                    sh_cnt_d = {SH_W{1'b0}};
                    state_d  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_l_d  = dd_step(bcd_l_q, bin_l_q[SCORE_W-1]);
                    bcd_r_d  = dd_step(bcd_r_q, bin_r_q[SCORE_W-1]);
                    bin_l_d  = bin_l_q << 1;
                    bin_r_d  = bin_r_q << 1;
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                    if (sh_cnt_q == SH_LAST) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_COMMIT: begin
                    disp_l_d = bcd_l_q;
                    disp_r_d = bcd_r_q;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Refresh counter, digit index, frame counter and blink phase.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                if (frame_q == FR_LAST) begin
                    frame_d = {FR_W{1'b0}};
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FR_W'(1);
                end
            end else begin
                frame_d = frame_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Digit select and segment/anode pattern for the next registered output.
    always_comb begin
        nib_s   = 4'd0;
        tens_s  = 1'b0;
        blink_s = 1'b0;
        case (idx_q)
            2'd0: begin nib_s = disp_r_q[3:0]; tens_s = 1'b0; blink_s = blink_r; end
            2'd1: begin nib_s = disp_r_q[7:4]; tens_s = 1'b1; blink_s = blink_r; end
            2'd2: begin nib_s = disp_l_q[3:0]; tens_s = 1'b0; blink_s = blink_l; end
            2'd3: begin nib_s = disp_l_q[7:4]; tens_s = 1'b1; blink_s = blink_l; end
            default: begin nib_s = 4'd0; tens_s = 1'b0; blink_s = 1'b0; end
        endcase
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (!en || (cnt_q == {CNT_W{1'b0}})) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d = ~(4'b0001 << idx_q);
            if ((blink_s && phase_q) || (tens_s && (nib_s == 4'd0))) begin
                seg_d = 7'b1111111;
            end else begin
                seg_d = seg7(nib_s);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bin_l_q  <= {SCORE_W{1'b0}};
            bin_r_q  <= {SCORE_W{1'b0}};
            bcd_l_q  <= 8'd0;
            bcd_r_q  <= 8'd0;
            disp_l_q <= 8'd0;
            disp_r_q <= 8'd0;
            sh_cnt_q <= {SH_W{1'b0}};
            busy_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= 2'd0;
            frame_q  <= {FR_W{1'b0}};
            phase_q  <= 1'b0;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
        end else begin
            state_q  <= state_d;
            bin_l_q  <= bin_l_d;
            bin_r_q  <= bin_r_d;
            bcd_l_q  <= bcd_l_d;
            bcd_r_q  <= bcd_r_d;
            disp_l_q <= disp_l_d;
            disp_r_q <= disp_r_d;
            sh_cnt_q <= sh_cnt_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_pong_score_scanner.sv
// Self-checking bench for pong_score_scanner: directed scenarios plus random stimulus,
// checked against a tick-count arithmetic model of the scoreboard.
module tb_pong_score_scanner;

    localparam int CLK_DIV      = 4;
    localparam int SCORE_W      = 7;
    localparam int BLINK_FRAMES = 2;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               score_valid;
    logic               blink_l;
    logic               blink_r;
    logic               busy;
    logic [6:0]         seg;
    logic [3:0]         an;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: ticks since reset release, displayed scores, pending conversion
    int m_tick, m_disp_l, m_disp_r, m_pend_l, m_pend_r, m_cd;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_busy;

    pong_score_scanner #(
        .CLK_DIV(CLK_DIV), .SCORE_W(SCORE_W), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .score_l(score_l), .score_r(score_r),
        .score_valid(score_valid), .blink_l(blink_l), .blink_r(blink_r),
        .busy(busy), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_tick = 0; m_disp_l = 0; m_disp_r = 0; m_cd = 0;
        m_pend_l = 0; m_pend_r = 0;
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_busy = 1'b0;
    endtask

    // Advance one clock; the model predicts the registered outputs from pre-edge inputs.
    task automatic step();
        int pos, dig, ph, val, d;
        logic [3:0] nan;
        logic [6:0] nseg;
        logic       blank;
        pos = m_tick % CLK_DIV;
        dig = (m_tick / CLK_DIV) % 4;
        ph  = ((m_tick / (4 * CLK_DIV)) / BLINK_FRAMES) % 2;
        nan  = 4'b1111;
        nseg = 7'b1111111;
        if (en && pos != 0) begin
            nan[dig] = 1'b0;
            val = (dig < 2) ? m_disp_r : m_disp_l;
            d = (dig % 2 == 0) ? (val % 10) : (val / 10);
            blank = (ph == 1) && ((dig < 2) ? blink_r : blink_l);
            if (dig % 2 == 1 && d == 0) blank = 1'b1;
            nseg = blank ? 7'b1111111 : digit_pat(d);
        end
        if (score_valid) begin
            m_pend_l = (int'(score_l) > 99) ? 99 : int'(score_l);
            m_pend_r = (int'(score_r) > 99) ? 99 : int'(score_r);
            m_cd = SCORE_W + 2;
        end else if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_disp_l = m_pend_l;
                m_disp_r = m_pend_r;
            end
        end
        @(posedge clk);
        exp_an   = nan;
        exp_seg  = nseg;
        exp_busy = (m_cd > 0);
        m_tick++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; score_l = '0; score_r = '0;
        score_valid = 1'b0; blink_l = 1'b0; blink_r = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset an=%b seg=%b busy=%b expected 1111 1111111 0", an, seg, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] first_an [4];
        for (int i = 0; i < 40; i++) begin
            step();
            if (i < 4) first_an[i] = an;
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL idle_scan cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
        end
        tests_run++;
        if (first_an[0] !== 4'b1111 || first_an[1] !== 4'b1110 || first_an[3] !== 4'b1110) begin
            tests_failed++;
            $display("FAIL idle_first_slot an=%b,%b,%b expected 1111,1110,1110",
                     first_an[0], first_an[1], first_an[3]);
        end
    endtask

    task automatic test_score_42_5();
        int busy_cnt = 0;
        score_l = 7'd42; score_r = 7'd5; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL score_42_5 cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
            if (i > 12) begin
                tests_run++;
                if ((an === 4'b0111 && seg !== 7'b1001100) || (an === 4'b1011 && seg !== 7'b0010010) ||
                    (an === 4'b1101 && seg !== 7'b1111111) || (an === 4'b1110 && seg !== 7'b0100100)) begin
                    tests_failed++;
                    $display("FAIL score_42_5_digit an=%b seg=%b", an, seg);
                end
            end
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        tests_run++;
        if (busy_cnt !== 9) begin
            tests_failed++;
            $display("FAIL busy_length got=%0d expected 9", busy_cnt);
        end
    endtask

    task automatic test_clamp();
        score_l = 7'd120; score_r = 7'd0; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL clamp cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
            if (i > 12 && (an === 4'b0111 || an === 4'b1011)) begin
                tests_run++;
                if (seg !== 7'b0000100) begin
                    tests_failed++;
                    $display("FAIL clamp_99 an=%b seg=%b expected 0000100", an, seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic seen42 = 1'b0;
        logic seen11 = 1'b0;
        score_l = 7'd42; score_r = 7'd0; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        repeat (3) step();
        score_l = 7'd11; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
            if (an === 4'b0111 && seg === 7'b1001100) seen42 = 1'b1;
            if (an === 4'b0111 && seg === 7'b1001111) seen11 = 1'b1;
        end
        tests_run++;
        if (seen42 !== 1'b0 || seen11 !== 1'b1) begin
            tests_failed++;
            $display("FAIL last_write_wins seen42=%b seen11=%b expected 0 1", seen42, seen11);
        end
    endtask

    task automatic test_blink();
        blink_r = 1'b1;
        for (int i = 0; i < 140; i++) begin
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL blink cyc=%0d an=%b seg=%b expected %b %b", i, an, seg, exp_an, exp_seg);
            end
        end
        blink_l = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL blink_both cyc=%0d an=%b seg=%b expected %b %b", i, an, seg, exp_an, exp_seg);
            end
        end
        blink_l = 1'b0; blink_r = 1'b0;
    endtask

    task automatic test_enable();
        for (int i = 0; i < 80; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL enable cyc=%0d en=%b an=%b seg=%b expected %b %b",
                         i, en, an, seg, exp_an, exp_seg);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            score_valid = ($urandom_range(0, 24) == 0);
            score_l = SCORE_W'($urandom_range(0, 127));
            score_r = SCORE_W'($urandom_range(0, 127));
            if ($urandom_range(0, 99) == 0) blink_l = ~blink_l;
            if ($urandom_range(0, 99) == 0) blink_r = ~blink_r;
            if ($urandom_range(0, 49) == 0) en = ~en;
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL random cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
        end
        score_valid = 1'b0; blink_l = 1'b0; blink_r = 1'b0; en = 1'b1;
    endtask

    task automatic test_async_reset();
        score_l = 7'd42; score_r = 7'd5; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        repeat (4) step();
        if (exp_an === 4'b1111) step();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset an=%b seg=%b busy=%b expected 1111 1111111 0", an, seg, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 48; i++) begin
            step();
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL after_reset cyc=%0d an=%b seg=%b busy=%b expected %b %b %b",
                         i, an, seg, busy, exp_an, exp_seg, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_score_42_5();
        test_clamp();
        test_back_to_back();
        test_blink();
        test_enable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pong_score_scanner.md
Name: pong_score_scanner

Overview:
- Time-multiplexed 4-digit 7-segment driver for the Pong scoreboard.
- Successor to the combinational single-digit decoder: adds a refresh scan, 0–99 scores per player, and a sequential binary-to-BCD converter.
- Also adds leading-zero blanking, per-player blink for the winner indication, and anti-ghosting dead time.
- Sits between the game-state/score logic and the board's seg/anode pins.

Parameters:
- CLK_DIV, 100000, clk cycles each digit is driven, including its dead cycle; minimum 2.
- SCORE_W, 7, width of each binary score input.
- BLINK_FRAMES, 32, full 4-digit scan frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; low blanks all outputs.
- score_l  in  SCORE_W  left player score, binary.
- score_r  in  SCORE_W  right player score, binary.
- score_valid  in  1  one-cycle load strobe for score_l/score_r.
- blink_l  in  1  blink left player's digits.
- blink_r  in  1  blink right player's digits.
- busy  out  1  BCD conversion in progress.
- seg  out  7  segments a..g on seg[6]..seg[0], active-low, registered.
- an  out  4  digit anodes, active-low, registered.

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - an=4'b1111, seg=7'b1111111, busy=0.
  - Digit index=0, refresh counter=0, frame counter=0, blink phase=0.
  - Displayed BCD for both players = 00.
- Reset mid-conversion or mid-scan abandons all state; no partial value is ever displayed.
- Digit map (an bit low = digit on):
  - an[0]: right units.
  - an[1]: right tens.
  - an[2]: left units.
  - an[3]: left tens.
- Decoding, digits 0–9 (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Conversion FSM, states IDLE → LOAD → SHIFT → COMMIT → IDLE:
  - score_valid in IDLE → LOAD: capture both scores; any value >99 is clamped to 99. busy=1 from the next cycle.
  - SHIFT: SCORE_W cycles of double-dabble for both players in parallel (add 3 to any nibble ≥5, then shift).
  - COMMIT: both players' displayed BCD update in the same cycle; busy=0 the following cycle.
  - Total latency from strobe to displayed-register update = SCORE_W+2 cycles.
  - score_valid while busy: restart at LOAD with the new values (last write wins). The old display is held until that conversion commits.
- Refresh scan:
  - Refresh counter counts 0..CLK_DIV-1 and wraps. At wrap, digit index increments modulo 4 (3→0).
  - Dead time: in the first cycle of each digit slot, an=4'b1111 and seg=7'b1111111.
  - For the remaining CLK_DIV-1 cycles, the indexed anode is low and seg holds that digit's pattern.
  - Outputs are registered, so they lag the counter state by one cycle.
- Leading-zero blanking: a tens digit equal to 0 shows seg=1111111 with its anode still low. Units always display, so a score of 0 shows "0".
- Blink:
  - Frame counter increments at each 3→0 index wrap. Every BLINK_FRAMES frames the blink phase toggles.
  - When blink_x=1 and phase=1, both of that player's digits show seg=1111111.
  - blink_l and blink_r are independent and may both be set; both sides then blank in phase.
- Enable: en=0 forces an=1111 and seg=1111111 from the next cycle. Counters and FSM keep running. Re-assert resumes mid-frame with no reset of the scan.
- Simultaneous score_valid and refresh wrap: independent; the scan reads the old BCD until COMMIT.

Test Plan (CLK_DIV=4, BLINK_FRAMES=2, SCORE_W=7):
- Reset then release, en=1, no scores → an sequence 1111 (dead), 1110 ×3, 1111, 1101 ×3, …; seg=0000001 on an[0] and an[2]; seg=1111111 on an[1] and an[3] (blanked zero tens).
- score_l=7'd42, score_r=7'd5, strobe → busy high for 9 cycles, display updates exactly at COMMIT:
  - an[3] → 1001100, an[2] → 0010010.
  - an[1] blank, an[0] → 0100100.
- score_l=7'd120 → left shows 99: seg=0000100 on both an[3] and an[2].
- Second strobe (left=11) 3 cycles into a conversion of left=42 → only 11 is ever displayed (1001111 on an[3] and an[2]); 42 never appears.
- blink_r=1 → right digits alternate between visible and blank every 2 frames (32 cycles); left digits are unaffected throughout.
- rst_n pulled low mid-SHIFT and mid-slot → an=1111, seg=1111111, busy=0 asynchronously; after release the display shows 00 blank-tens and the scan restarts at digit 0.
